// File: rtl/led_pkg.sv
// Shared front-panel/LED definitions: button FSM states, clock rate and the
// blink-mode on/off table used by both the mode selector and the blinker.
package led_pkg;

    localparam int unsigned CLK_HZ = 27000000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        RELEASE_DB = 3'd4
    } btn_state_t;

    typedef struct packed {
        logic [3:0] on_secs;
        logic [3:0] off_secs;
    } mode_times_t;

    // Modes beyond the four table entries wrap onto entry (mode % 4).
    function automatic mode_times_t mode_times(input logic [3:0] mode);
        mode_times_t t;
        case (mode & 4'd3)
            4'd0:    t = '{on_secs: 4'd2, off_secs: 4'd1};
            4'd1:    t = '{on_secs: 4'd1, off_secs: 4'd3};
            4'd2:    t = '{on_secs: 4'd1, off_secs: 4'd1};
            4'd3:    t = '{on_secs: 4'd3, off_secs: 4'd0};
            default: t = '{on_secs: 4'd2, off_secs: 4'd1};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous board inputs; the reset value is
// chosen per input so the idle level is seen while in reset.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Metastability filter: d -> meta_r -> q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/btn_mode_sel.sv
// Debounced push-button front end: short press steps the blink mode, long
// press returns to mode 0; drives registered on/off times and a reload pulse.
module btn_mode_sel
    import led_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 540000,
    parameter int unsigned LONG_CYCLES = 27000000,
    parameter int unsigned NUM_MODES   = 4,
    localparam int unsigned MODE_W     = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    output logic [MODE_W-1:0] mode,
    output logic              mode_pulse,
    output logic [3:0]        on_secs,
    output logic [3:0]        off_secs,
    output logic              btn_level
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic              btn_s;
    btn_state_t        state_r;
    btn_state_t        state_s;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [DEB_W-1:0]  deb_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic              long_flag_r;
    logic              long_flag_s;
    logic [MODE_W-1:0] mode_s;
    logic              pulse_s;
    mode_times_t       times_s;
    logic              level_s;

    // btn_s is 1 while released; reset value keeps the FSM idle.
    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_s)
    );

    // Next-state, counter and mode-update logic for the press classifier.
    always_comb begin
        state_s     = state_r;
        deb_cnt_s   = deb_cnt_r;
        hold_cnt_s  = hold_cnt_r;
        long_flag_s = long_flag_r;
        mode_s      = mode;
        pulse_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!btn_s) begin
                    state_s   = PRESS_DB;
                    deb_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_DB: begin
                if (btn_s) begin
                    state_s = IDLE;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_s    = HELD;
                    hold_cnt_s = '0;
                    deb_cnt_s  = '0;
                end else begin
                    deb_cnt_s = deb_cnt_r + DEB_W'(1);
                end
            end
            HELD: begin
                // Long press takes priority over a release seen in the same cycle.
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s = LONG_HELD;
                    mode_s  = '0;
                    pulse_s = 1'b1;
                end else if (btn_s) begin
                    state_s     = RELEASE_DB;
                    long_flag_s = 1'b0;
                    deb_cnt_s   = '0;
                    hold_cnt_s  = hold_cnt_r + HOLD_W'(1);
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (btn_s) begin
                    state_s     = RELEASE_DB;
                    long_flag_s = 1'b1;
                    deb_cnt_s   = '0;
                end else begin
                    state_s = LONG_HELD;
                end
            end
            RELEASE_DB: begin
                // A re-press resumes hold timing where it left off.
                if (!btn_s) begin
                    state_s = long_flag_r ? LONG_HELD : HELD;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_s   = IDLE;
                    deb_cnt_s = '0;
                    if (!long_flag_r) begin
                        mode_s  = (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
                        pulse_s = 1'b1;
                    end else begin
                        mode_s = mode;
                    end
                end else begin
                    deb_cnt_s = deb_cnt_r + DEB_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign times_s = mode_times(4'(mode_s));
    assign level_s = (state_s == HELD) || (state_s == LONG_HELD) ||
                     (state_s == RELEASE_DB);

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            deb_cnt_r   <= '0;
            hold_cnt_r  <= '0;
            long_flag_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            deb_cnt_r   <= deb_cnt_s;
            hold_cnt_r  <= hold_cnt_s;
            long_flag_r <= long_flag_s;
        end
    end

    // Registered outputs; mode, times and pulse change on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode       <= '0;
            mode_pulse <= 1'b0;
            on_secs    <= 4'd2;
            off_secs   <= 4'd1;
            btn_level  <= 1'b0;
        end else begin
            mode       <= mode_s;
            mode_pulse <= pulse_s;
            on_secs    <= times_s.on_secs;
            off_secs   <= times_s.off_secs;
            btn_level  <= level_s;
        end
    end

endmodule

// File: tb/tb_btn_mode_sel.sv
// Self-checking bench for btn_mode_sel with short debounce/long-press times;
// a run-length reference model predicts every output each cycle.
module tb_btn_mode_sel;

    localparam int DEB  = 8;
    localparam int LONG = 64;
    localparam int NM   = 4;

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic [1:0] mode;
    logic       mode_pulse;
    logic [3:0] on_secs;
    logic [3:0] off_secs;
    logic       btn_level;

    int n_checks = 0;
    int n_fail   = 0;

    int on_tab  [4] = '{2, 1, 1, 3};
    int off_tab [4] = '{1, 3, 1, 0};

    // Reference model: two-sample input delay, debounced level, length of the
    // current run of samples disagreeing with that level, held time, long flag.
    bit m_q1, m_q2, m_lvl, m_long, m_pulse;
    int m_run, m_hold, m_mode;

    btn_mode_sel #(
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG),
        .NUM_MODES   (NM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .mode       (mode),
        .mode_pulse (mode_pulse),
        .on_secs    (on_secs),
        .off_secs   (off_secs),
        .btn_level  (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q1 = 1'b1; m_q2 = 1'b1; m_lvl = 1'b0; m_long = 1'b0; m_pulse = 1'b0;
        m_run = 0; m_hold = 0; m_mode = 0;
    endtask

    // A level change needs DEB+1 consecutive opposite samples; a long press
    // fires after LONG samples counted while pressed and not releasing.
    task automatic model_step(input bit b);
        bit p;
        p = !m_q2;
        m_q2 = m_q1;
        m_q1 = b;
        m_pulse = 1'b0;
        if (!m_lvl) begin
            if (p) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = 1'b1; m_run = 0; m_hold = 0; m_long = 1'b0;
                end
            end else begin
                m_run = 0;
            end
        end else if (m_run == 0 && !m_long) begin
            m_hold++;
            if (m_hold == LONG) begin
                m_long = 1'b1; m_mode = 0; m_pulse = 1'b1;
            end else if (!p) begin
                m_run = 1;
            end
        end else if (m_run == 0) begin
            if (!p) m_run = 1;
        end else if (p) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_lvl = 1'b0; m_run = 0;
                if (!m_long) begin
                    m_mode = (m_mode + 1) % NM; m_pulse = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [11:0] exp_vec();
        return {2'(m_mode), m_pulse, 4'(on_tab[m_mode % 4]), 4'(off_tab[m_mode % 4]), m_lvl};
    endfunction

    // Drive at the falling edge, advance one rising edge, land on the next falling edge.
    task automatic cyc(input bit b);
        btn_n = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        btn_n = 1'b1;
        rst   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            n_checks++;
            if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== 12'b00_0_0010_0001_0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", i,
                         {mode, mode_pulse, on_secs, off_secs, btn_level}, 12'b00_0_0010_0001_0);
            end
        end
    endtask

    task automatic test_short_press();
        int pulses = 0;
        int pulse_at = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0);
            n_checks++;
            if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                n_fail++;
                $display("FAIL short_press hold %0d: got %h expected %h", i,
                         {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
            end
        end
        for (int k = 1; k <= 25; k++) begin
            cyc(1'b1);
            if (mode_pulse) begin pulses++; pulse_at = k; end
            n_checks++;
            if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                n_fail++;
                $display("FAIL short_press release %0d: got %h expected %h", k,
                         {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
            end
        end
        n_checks++;
        if (pulses !== 1 || pulse_at !== DEB + 3) begin
            n_fail++;
            $display("FAIL short_press latency: got %0d pulses at %0d, expected 1 at %0d",
                     pulses, pulse_at, DEB + 3);
        end
        n_checks++;
        if ({mode, on_secs, off_secs} !== {2'd1, 4'd1, 4'd3}) begin
            n_fail++;
            $display("FAIL short_press mode: got %h expected %h",
                     {mode, on_secs, off_secs}, {2'd1, 4'd1, 4'd3});
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc((i < 30) ? bit'((i / 3) % 2) : 1'b1);
            if (btn_level || mode_pulse || mode !== 2'd1) bad++;
            n_checks++;
            if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: got %h expected %h", i,
                         {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bounce reaction: got %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_mode_cycle();
        int pulses = 0;
        logic [7:0] seq = 8'h00;
        logic [7:0] steady = 8'h00;
        pulse_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 27; i++) begin
                cyc((i < 12) ? 1'b0 : 1'b1);
                if (mode_pulse) begin
                    seq = {seq[5:0], mode};
                    pulses++;
                    if (mode == 2'd3) steady = {on_secs, off_secs};
                end
                n_checks++;
                if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL mode_cycle press %0d cycle %0d: got %h expected %h", p, i,
                             {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
                end
            end
        end
        n_checks++;
        if (pulses !== 4 || seq !== 8'b01_10_11_00 || steady !== 8'h30) begin
            n_fail++;
            $display("FAIL mode_cycle sequence: got %0d pulses seq %b steady %h, expected 4 01101100 30",
                     pulses, seq, steady);
        end
    endtask

    task automatic test_long_press();
        int pulses = 0;
        int pulse_at = -1;
        bit rel_pat [28] = '{1,1,0,0,1,1,0,0, 1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 27; i++) cyc((i < 12) ? 1'b0 : 1'b1);
        n_checks++;
        if (mode !== 2'd2) begin
            n_fail++;
            $display("FAIL long_press setup mode: got %0d expected 2", mode);
        end
        for (int k = 1; k <= 100 + 28; k++) begin
            cyc((k <= 100) ? 1'b0 : rel_pat[k - 101]);
            if (mode_pulse) begin pulses++; pulse_at = k; end
            n_checks++;
            if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                n_fail++;
                $display("FAIL long_press cycle %0d: got %h expected %h", k,
                         {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
            end
        end
        n_checks++;
        if (pulses !== 1 || pulse_at !== 2 + DEB + LONG + 1 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL long_press pulse: got %0d pulses at %0d mode %0d, expected 1 at %0d mode 0",
                     pulses, pulse_at, mode, 2 + DEB + LONG + 1);
        end
    endtask

    task automatic test_reset_mid_press();
        int rise_at = -1;
        for (int i = 0; i < 27; i++) cyc((i < 12) ? 1'b0 : 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0);
        n_checks++;
        if ({mode, btn_level} !== 3'b01_1) begin
            n_fail++;
            $display("FAIL mid_press setup: got %b expected 011", {mode, btn_level});
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== 12'b00_0_0010_0001_0) begin
            n_fail++;
            $display("FAIL mid_press reset: got %h expected %h",
                     {mode, mode_pulse, on_secs, off_secs, btn_level}, 12'b00_0_0010_0001_0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0);
            if (btn_level && rise_at < 0) rise_at = k;
            n_checks++;
            if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                n_fail++;
                $display("FAIL mid_press cycle %0d: got %h expected %h", k,
                         {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
            end
        end
        // Two synchroniser cycles, one IDLE decision, then the full debounce.
        n_checks++;
        if (rise_at !== 2 + 1 + DEB) begin
            n_fail++;
            $display("FAIL mid_press level: got rise at %0d expected %0d", rise_at, 2 + 1 + DEB);
        end
        for (int i = 0; i < 15; i++) cyc(1'b1);
    endtask

    task automatic test_random();
        bit b = 1'b1;
        int len;
        for (int r = 0; r < 300; r++) begin
            b   = ~b;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(66, 90))
                                              : int'($urandom_range(1, 14));
            for (int j = 0; j < len; j++) begin
                cyc(b);
                n_checks++;
                if ({mode, mode_pulse, on_secs, off_secs, btn_level} !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random run %0d cycle %0d: got %h expected %h", r, j,
                             {mode, mode_pulse, on_secs, off_secs, btn_level}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        btn_n = 1'b1;
        rst   = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_short_press();
        test_bounce();
        test_mode_cycle();
        test_long_press();
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
